if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port imem_req, output, 1, instruction memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, instruction memory byte address, word-aligned.
REQ-006 The block SHALL have port imem_rdata, input, 32, read data, valid exactly one cycle after the cycle imem_req=1.
REQ-007 The block SHALL have port redirect, input, 1, branch/jump redirect from the execute stage.
REQ-008 The block SHALL have port redirect_pc, input, 32, redirect target.
REQ-009 The block SHALL have port if_valid, output, 1, instruction available to decode.
REQ-010 The block SHALL have port if_ready, input, 1, decode accepts the instruction.
REQ-011 The block SHALL have port if_instr, output, 32, instruction word at the queue head.
REQ-012 The block SHALL have port if_pc, output, 32, address of if_instr.
REQ-013 The block SHALL have port if_pc4, output, 32, if_pc+4, modulo 2^32.

Function
REQ-014 The block SHALL hold a fetch PC register, a 2-entry FIFO of {instr, pc}, an in-flight flag and a discard flag.
REQ-015 The block SHALL drive imem_addr = fetch PC at all times.
REQ-016 The block SHALL define pop = if_valid & if_ready; a transfer occurs only on that cycle's rising edge.
REQ-017 The block SHALL assert imem_req combinationally when redirect=0 and (entries + in-flight - pop) < 2.
REQ-018 On an edge with imem_req=1, the block SHALL set fetch PC <= fetch PC + 4 (wraps 32'hFFFF_FFFC -> 0) and set in-flight, tagging it with the issued address.
REQ-019 On the edge after a request, the block SHALL write {imem_rdata, tagged address} into the FIFO tail unless discard is set; in-flight clears if no new request issues.
REQ-020 The block SHALL support simultaneous push and pop in one cycle; the FIFO never overflows (guaranteed by REQ-017).
REQ-021 The block SHALL drive if_valid=1 iff FIFO non-empty; if_instr/if_pc/if_pc4 come from the head entry and hold stable while if_valid=1 and if_ready=0.
REQ-022 With if_ready held 1 and no redirect, the block SHALL sustain one instruction per cycle.
REQ-023 Latency: request in cycle N -> if_valid with that instruction in cycle N+2 when the FIFO was empty.
REQ-024 On an edge with redirect=1, the block SHALL: empty the FIFO, set discard if a request is in flight, set fetch PC <= {redirect_pc[31:2], 2'b00}, issue no request that cycle.
REQ-025 A pop in the redirect cycle SHALL still count as delivered to decode; redirect overrides all other queue updates.
REQ-026 Discard SHALL clear on the edge the discarded response arrives; that response is never written.
REQ-027 Back-to-back redirects SHALL each apply; the last one determines fetch PC.

Reset
REQ-028 While rst_n=0: fetch PC = RESET_PC, FIFO empty, in-flight=0, discard=0, if_valid=0, if_instr/if_pc/if_pc4 = 0, imem_req=0.
REQ-029 Reset assertion mid-operation SHALL take effect immediately; any in-flight response after release is ignored.
REQ-030 First request SHALL issue in the first cycle after rst_n rises, at RESET_PC.

Verification
REQ-031 Reset release, if_ready=1, memory word = address -> if_valid from cycle 2, if_pc = 0,4,8,... one per cycle, if_pc4 = if_pc+4.
REQ-032 if_ready=0 for 5 cycles after first valid -> exactly 2 entries held, imem_req=0, if_instr stable; resume -> no address skipped or duplicated.
REQ-033 redirect=1, redirect_pc=32'h0000_0103 while one request in flight -> FIFO empties, in-flight data dropped, next request at 32'h0000_0100, first new if_pc=32'h100.
REQ-034 RESET_PC=32'hFFFF_FFF8, if_ready=1 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc4 of FFFF_FFFC = 0.
REQ-035 redirect on two consecutive cycles (targets 0x40, 0x80) -> no instruction from 0x40 delivered; first if_pc = 0x80.
REQ-036 rst_n pulsed low mid-stream with FIFO full -> outputs zero immediately, restart at RESET_PC, no stale instruction delivered.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, one-cycle-latency
// memory interface and a 2-entry {instr, pc} queue feeding decode.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      fifo [2];
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic [31:0] fetch_pc;
    logic [31:0] tag_pc;
    logic        inflight;
    logic        discard;
    logic        pop;
    logic        push;
    logic [2:0]  occupancy;

    assign if_valid  = (count != 2'd0);
    assign pop       = if_valid & if_ready;
    assign push      = inflight & ~discard;
    assign tail      = head ^ count[0];
    assign imem_addr = fetch_pc;

    // Slots already committed (queued or in flight) after this cycle's pop;
    // requesting only below 2 is what keeps the queue from overflowing.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign imem_req  = rst_n & ~redirect & (occupancy < 3'd2);

    assign if_instr = if_valid ? fifo[head].instr : '0;
    assign if_pc    = if_valid ? fifo[head].pc : '0;
    assign if_pc4   = if_valid ? (fifo[head].pc + 32'd4) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            tag_pc   <= '0;
            count    <= 2'd0;
            head     <= 1'b0;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else if (redirect) begin
            // The response arriving on this edge belongs to the old stream.
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            count    <= 2'd0;
            head     <= 1'b0;
            inflight <= 1'b0;
            discard  <= inflight;
        end else begin
            discard  <= 1'b0;
            count    <= count + {1'b0, push} - {1'b0, pop};
            inflight <= imem_req;
            if (pop) begin
                head <= ~head;
            end
            if (imem_req) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            fifo[tail] <= '{instr: imem_rdata, pc: tag_pc};
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model of the fetch stream,
// directed scenarios plus a randomized ready/redirect run.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;

    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_if_ready;
    logic [31:0] w_imem_rdata;
    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic [31:0] w_if_pc4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_fetch_queue dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc4(if_pc4)
    );

    if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_pc4(w_if_pc4)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    always @(posedge clk) imem_rdata <= memf(imem_addr);
    always @(posedge clk) w_imem_rdata <= memf(w_imem_addr);

    // Reference model: queue of pcs awaiting decode plus one outstanding fetch.
    logic [31:0] m_fpc;
    logic [31:0] m_tag;
    bit          m_infl;
    logic [31:0] m_q [$];

    task automatic m_reset();
        m_q.delete();
        m_fpc  = 32'h0;
        m_tag  = 32'h0;
        m_infl = 1'b0;
    endtask

    function automatic bit m_req();
        int pop;
        pop = (m_q.size() > 0 && if_ready) ? 1 : 0;
        return rst_n && !redirect && (m_q.size() + int'(m_infl) - pop < 2);
    endfunction

    function automatic logic [129:0] exp_vec();
        if (m_q.size() > 0)
            return {1'b1, m_q[0], memf(m_q[0]), m_q[0] + 32'd4, m_req(), m_fpc};
        return {1'b0, 96'b0, m_req(), m_fpc};
    endfunction

    function automatic logic [129:0] got_vec();
        return {if_valid, if_pc, if_instr, if_pc4, imem_req, imem_addr};
    endfunction

    task automatic tick();
        bit req;
        if (!rst_n) begin
            m_reset();
        end else begin
            req = m_req();
            if (redirect) begin
                m_q.delete();
                m_fpc  = redirect_pc & 32'hFFFF_FFFC;
                m_infl = 1'b0;
            end else begin
                if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
                if (m_infl) m_q.push_back(m_tag);
                if (req) begin
                    m_tag  = m_fpc;
                    m_fpc  = m_fpc + 32'd4;
                    m_infl = 1'b1;
                end else begin
                    m_infl = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit r, input bit d, input logic [31:0] p);
        if_ready    = r;
        redirect    = d;
        redirect_pc = p;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec() || imem_req !== 1'b0 || if_pc4 !== 32'h0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_vec cyc=%0d got=%h exp=%h", cyc, got_vec(), exp_vec());
            end
            checks++;
            if (cyc < 2 && if_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_early_valid cyc=%0d got=%b exp=0", cyc, if_valid);
            end else if (cyc >= 2 && (if_valid !== 1'b1 || if_pc !== 32'(4 * (cyc - 2))
                                      || if_pc4 !== 32'(4 * (cyc - 1)))) begin
                errors++;
                $display("FAIL stream_pc cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, if_valid,
                         if_pc, if_pc4, 32'(4 * (cyc - 2)), 32'(4 * (cyc - 1)));
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic [31:0] next_pc;
        held_pc    = if_pc;
        held_instr = if_instr;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec() || if_pc !== held_pc || if_instr !== held_instr) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got=%h exp=%h held=%h", i, got_vec(), exp_vec(), held_pc);
            end
            tick();
        end
        set_in(1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b0 || m_q.size() != 2) begin
            errors++;
            $display("FAIL stall_full got_req=%b model_entries=%0d exp_req=0 entries=2", imem_req, m_q.size());
        end
        next_pc = held_pc;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec() || if_valid !== 1'b1 || if_pc !== next_pc) begin
                errors++;
                $display("FAIL stall_resume cyc=%0d got_pc=%h exp_pc=%h", i, if_pc, next_pc);
            end
            next_pc = next_pc + 32'd4;
            tick();
        end
    endtask

    task automatic test_redirect();
        bit seen;
        set_in(1'b1, 1'b1, 32'h0000_0103);
        checks++;
        if (got_vec() !== exp_vec() || imem_req !== 1'b0 || !m_infl) begin
            errors++;
            $display("FAIL redir_cycle got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        set_in(1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_next_req got=%b/%h/%b exp=1/00000100/0", imem_req, imem_addr, if_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL redir_vec cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
            if (if_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (if_pc !== 32'h0000_0100) begin
                    errors++;
                    $display("FAIL redir_first_pc got=%h exp=00000100", if_pc);
                end
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL redir_timeout got=no_valid exp=valid");
        end
    endtask

    task automatic test_double_redirect();
        bit seen;
        set_in(1'b1, 1'b1, 32'h0000_0040);
        tick();
        set_in(1'b1, 1'b1, 32'h0000_0080);
        checks++;
        if (got_vec() !== exp_vec() || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL dbl_redir_cycle got=%h exp=%h", got_vec(), exp_vec());
        end
        tick();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec() || (if_valid === 1'b1 && if_pc[31:6] == 26'h1)) begin
                errors++;
                $display("FAIL dbl_redir_vec cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
            if (if_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (if_pc !== 32'h0000_0080) begin
                    errors++;
                    $display("FAIL dbl_redir_first_pc got=%h exp=00000080", if_pc);
                end
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dbl_redir_timeout got=no_valid exp=valid");
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 32'h0);
            tick();
        end
        checks++;
        if (if_valid !== 1'b1 || m_q.size() != 2) begin
            errors++;
            $display("FAIL rstmid_full got_valid=%b model_entries=%0d exp=1/2", if_valid, m_q.size());
        end
        rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc4 !== 32'h0
            || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_zero got=%h exp=all_zero", got_vec());
        end
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_vec cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
            if (if_valid === 1'b1 && !seen) begin
                seen = 1'b1;
                checks++;
                if (if_pc !== 32'h0 || i != 2) begin
                    errors++;
                    $display("FAIL rstmid_restart got_pc=%h cyc=%0d exp_pc=00000000 cyc=2", if_pc, i);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        bit r;
        bit d;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 11) == 0);
            set_in(r, d, $urandom);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_vec cyc=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seq [$];
        rst_n = 1'b0;
        set_in(1'b1, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b0, 32'h0);
            if (w_if_valid === 1'b1) begin
                seq.push_back(w_if_pc);
                checks++;
                if (w_if_pc4 !== w_if_pc + 32'd4 || w_if_instr !== memf(w_if_pc)) begin
                    errors++;
                    $display("FAIL wrap_entry pc=%h got=%h/%h exp=%h/%h", w_if_pc, w_if_pc4,
                             w_if_instr, w_if_pc + 32'd4, memf(w_if_pc));
                end
                if (w_if_pc === 32'hFFFF_FFFC) begin
                    checks++;
                    if (w_if_pc4 !== 32'h0) begin
                        errors++;
                        $display("FAIL wrap_pc4 got=%h exp=00000000", w_if_pc4);
                    end
                end
            end
            tick();
        end
        checks++;
        if (seq.size() < 3 || seq[0] !== 32'hFFFF_FFF8 || seq[1] !== 32'hFFFF_FFFC
            || seq[2] !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_sequence got_count=%0d exp=FFFFFFF8,FFFFFFFC,00000000", seq.size());
        end
    endtask

    initial begin
        w_if_ready    = 1'b1;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        rst_n         = 1'b0;
        if_ready      = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_double_redirect();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
